// File: rtl/axil_cfg_initiator.sv
// -----------------------------------------------------------------------------
// axil_cfg_initiator
//
// Single-outstanding AXI4-Lite initiator. Each command accepted on the cmd_*
// port runs exactly one AXI-Lite read or write; the outcome comes back on the
// rsp_* port. Typical targets are the stream switch control slave or any
// other AXI-Lite register block on the shell clock.
//
// Handshake rule (cmd_*, rsp_* and every AXI channel): a beat transfers on a
// rising clock edge where valid and ready are both high. A source holds valid
// and its payload stable until that edge; ready may toggle freely.
//
// Ports
//   axil_aclk, axil_rst     clock, synchronous active-high reset
//   cmd_valid/ready         command handshake
//   cmd_write/addr/wdata    1 = write, target address, write data
//   rsp_valid/ready         response handshake
//   rsp_rdata/resp/timeout  read data (0 for writes), BRESP/RRESP, abort flag
//   m_axil_aw*/w*/b*        AXI-Lite write channels (wstrb fixed at 4'hF)
//   m_axil_ar*/r*           AXI-Lite read channels
//   stat_*_cnt              transaction statistics (optional, see below)
//   dbg_state               current FSM state encoding
//
// Optional feature: define AXIL_CFG_INITIATOR_STATS_EN to add the
// stat_wr_cnt / stat_rd_cnt / stat_err_cnt outputs.
//
// Timeout: with TIMEOUT_CYCLES > 0 each phase (request acceptance, then
// response) may last at most TIMEOUT_CYCLES cycles. On expiry all AXI
// valids/readies drop and the response reports rsp_resp = 2'b10 with
// rsp_timeout = 1. TIMEOUT_CYCLES = 0 waits forever.
// -----------------------------------------------------------------------------
module axil_cfg_initiator #(
    parameter int ADDR_W         = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic              axil_aclk,
    input  logic              axil_rst,

    // Command port
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [31:0]       cmd_wdata,

    // Response port
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic [1:0]        rsp_resp,
    output logic              rsp_timeout,

    // AXI-Lite write address
    output logic              m_axil_awvalid,
    output logic [ADDR_W-1:0] m_axil_awaddr,
    input  logic              m_axil_awready,

    // AXI-Lite write data
    output logic              m_axil_wvalid,
    output logic [31:0]       m_axil_wdata,
    output logic [3:0]        m_axil_wstrb,
    input  logic              m_axil_wready,

    // AXI-Lite write response
    input  logic              m_axil_bvalid,
    input  logic [1:0]        m_axil_bresp,
    output logic              m_axil_bready,

    // AXI-Lite read address
    output logic              m_axil_arvalid,
    output logic [ADDR_W-1:0] m_axil_araddr,
    input  logic              m_axil_arready,

    // AXI-Lite read data
    input  logic              m_axil_rvalid,
    input  logic [31:0]       m_axil_rdata,
    input  logic [1:0]        m_axil_rresp,
    output logic              m_axil_rready,

`ifdef AXIL_CFG_INITIATOR_STATS_EN
    output logic [31:0]       stat_wr_cnt,
    output logic [31:0]       stat_rd_cnt,
    output logic [31:0]       stat_err_cnt,
`endif

    // Debug
    output logic [2:0]        dbg_state
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR_REQ  = 3'd1,
        ST_WR_RESP = 3'd2,
        ST_RD_REQ  = 3'd3,
        ST_RD_RESP = 3'd4,
        ST_RSP     = 3'd5
    } state_t;

    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;
    localparam bit          TMO_EN      = (TIMEOUT_CYCLES > 0);
    localparam logic [15:0] TMO_LAST    = TMO_EN ? 16'(TIMEOUT_CYCLES - 1) : 16'd0;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    state_t              state_q,       state_d;
    logic [15:0]         tmo_q,         tmo_d;
    logic                cmd_ready_q,   cmd_ready_d;
    logic [ADDR_W-1:0]   addr_q,        addr_d;
    logic [31:0]         wdata_q,       wdata_d;
    logic                write_q,       write_d;
    logic                awvalid_q,     awvalid_d;
    logic                wvalid_q,      wvalid_d;
    logic                arvalid_q,     arvalid_d;
    logic                bready_q,      bready_d;
    logic                rready_q,      rready_d;
    logic                rsp_valid_q,   rsp_valid_d;
    logic [31:0]         rsp_rdata_q,   rsp_rdata_d;
    logic [1:0]          rsp_resp_q,    rsp_resp_d;
    logic                rsp_timeout_q, rsp_timeout_d;

    logic                tmo_hit;
    logic                abort;

    // Last permitted cycle of the current phase.
    assign tmo_hit = TMO_EN && (tmo_q == TMO_LAST);

    // -------------------------------------------------------------------------
    // Next-state / output logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        write_d       = write_q;
        awvalid_d     = awvalid_q;
        wvalid_d      = wvalid_q;
        arvalid_d     = arvalid_q;
        bready_d      = bready_q;
        rready_d      = rready_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_resp_d    = rsp_resp_q;
        rsp_timeout_d = rsp_timeout_q;
        abort         = 1'b0;
        cmd_ready_d   = 1'b0;
        tmo_d         = 16'd0;

        unique case (state_q)
            ST_IDLE: begin
                // cmd_ready_q (not the state) qualifies the handshake so the
                // cycle right after reset never accepts a command.
                if (cmd_valid && cmd_ready_q) begin
                    addr_d  = cmd_addr;
                    wdata_d = cmd_wdata;
                    write_d = cmd_write;
                    if (cmd_write) begin
                        state_d   = ST_WR_REQ;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                    end else begin
                        state_d   = ST_RD_REQ;
                        arvalid_d = 1'b1;
                    end
                end
            end

            ST_WR_REQ: begin
                // AW and W retire independently, in any order or together.
                if (awvalid_q && m_axil_awready) awvalid_d = 1'b0;
                if (wvalid_q  && m_axil_wready)  wvalid_d  = 1'b0;
                if (!awvalid_d && !wvalid_d) begin
                    state_d  = ST_WR_RESP;
                    bready_d = 1'b1;
                end else if (tmo_hit) begin
                    abort = 1'b1;
                end
            end

            ST_WR_RESP: begin
                if (m_axil_bvalid) begin
                    state_d       = ST_RSP;
                    bready_d      = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_resp_d    = m_axil_bresp;
                    rsp_rdata_d   = 32'd0;
                    rsp_timeout_d = 1'b0;
                end else if (tmo_hit) begin
                    abort = 1'b1;
                end
            end

            ST_RD_REQ: begin
                if (m_axil_arready) begin
                    state_d   = ST_RD_RESP;
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                end else if (tmo_hit) begin
                    abort = 1'b1;
                end
            end

            ST_RD_RESP: begin
                if (m_axil_rvalid) begin
                    state_d       = ST_RSP;
                    rready_d      = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_resp_d    = m_axil_rresp;
                    rsp_rdata_d   = m_axil_rdata;
                    rsp_timeout_d = 1'b0;
                end else if (tmo_hit) begin
                    abort = 1'b1;
                end
            end

            ST_RSP: begin
                if (rsp_ready) begin
                    state_d     = ST_IDLE;
                    rsp_valid_d = 1'b0;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A beat completing in the expiry cycle is handled above and never
        // reaches here, so completion beats the timeout.
        if (abort) begin
            state_d       = ST_RSP;
            awvalid_d     = 1'b0;
            wvalid_d      = 1'b0;
            arvalid_d     = 1'b0;
            bready_d      = 1'b0;
            rready_d      = 1'b0;
            rsp_valid_d   = 1'b1;
            rsp_resp_d    = RESP_SLVERR;
            rsp_rdata_d   = 32'd0;
            rsp_timeout_d = 1'b1;
        end

        cmd_ready_d = (state_d == ST_IDLE);

        // Phase timer: restarts on every state change, counts only while an
        // AXI phase is outstanding.
        if (state_d != state_q) begin
            tmo_d = 16'd0;
        end else if (state_q == ST_WR_REQ || state_q == ST_WR_RESP ||
                     state_q == ST_RD_REQ || state_q == ST_RD_RESP) begin
            tmo_d = tmo_q + 16'd1;
        end
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    always_ff @(posedge axil_aclk) begin
        if (axil_rst) begin
            state_q       <= ST_IDLE;
            tmo_q         <= 16'd0;
            cmd_ready_q   <= 1'b0;
            addr_q        <= '0;
            wdata_q       <= 32'd0;
            write_q       <= 1'b0;
            awvalid_q     <= 1'b0;
            wvalid_q      <= 1'b0;
            arvalid_q     <= 1'b0;
            bready_q      <= 1'b0;
            rready_q      <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= 32'd0;
            rsp_resp_q    <= RESP_OKAY;
            rsp_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            tmo_q         <= tmo_d;
            cmd_ready_q   <= cmd_ready_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            write_q       <= write_d;
            awvalid_q     <= awvalid_d;
            wvalid_q      <= wvalid_d;
            arvalid_q     <= arvalid_d;
            bready_q      <= bready_d;
            rready_q      <= rready_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_resp_q    <= rsp_resp_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end

`ifdef AXIL_CFG_INITIATOR_STATS_EN
    // -------------------------------------------------------------------------
    // Statistics: counted when a response is consumed (RSP -> IDLE).
    // -------------------------------------------------------------------------
    logic [31:0] stat_wr_q;
    logic [31:0] stat_rd_q;
    logic [31:0] stat_err_q;
    logic        rsp_done;

    assign rsp_done = (state_q == ST_RSP) && rsp_ready;

    always_ff @(posedge axil_aclk) begin
        if (axil_rst) begin
            stat_wr_q  <= 32'd0;
            stat_rd_q  <= 32'd0;
            stat_err_q <= 32'd0;
        end else if (rsp_done) begin
            if (write_q) stat_wr_q <= stat_wr_q + 32'd1;
            else         stat_rd_q <= stat_rd_q + 32'd1;
            if (rsp_resp_q != RESP_OKAY || rsp_timeout_q)
                stat_err_q <= stat_err_q + 32'd1;
        end
    end

    assign stat_wr_cnt  = stat_wr_q;
    assign stat_rd_cnt  = stat_rd_q;
    assign stat_err_cnt = stat_err_q;
`endif

    // -------------------------------------------------------------------------
    // Outputs (all registered)
    // -------------------------------------------------------------------------
    assign cmd_ready      = cmd_ready_q;
    assign rsp_valid      = rsp_valid_q;
    assign rsp_rdata      = rsp_rdata_q;
    assign rsp_resp       = rsp_resp_q;
    assign rsp_timeout    = rsp_timeout_q;

    assign m_axil_awvalid = awvalid_q;
    assign m_axil_awaddr  = addr_q;
    assign m_axil_wvalid  = wvalid_q;
    assign m_axil_wdata   = wdata_q;
    assign m_axil_wstrb   = 4'hF;
    assign m_axil_bready  = bready_q;
    assign m_axil_arvalid = arvalid_q;
    assign m_axil_araddr  = addr_q;
    assign m_axil_rready  = rready_q;

    assign dbg_state      = state_q;

endmodule

// File: doc/axil_cfg_initiator.md
Name: axil_cfg_initiator

Overview:
- AXI4-Lite initiator (master) that drives the stream switch's AXI-Lite control slave. It can equally drive any other AXI-Lite register slave on the 250 MHz shell.
- Takes single-word read or write commands on a valid/ready command port and runs exactly one AXI-Lite transaction per command. Returns data, response code and a timeout flag on a valid/ready response port.
- Used by bench sequencers and by on-chip bring-up logic that programs switch routing without host PCIe access.

Parameters:
- ADDR_W, 32, AXI-Lite address width.
- TIMEOUT_CYCLES, 1024, cycles allowed per phase (address/data acceptance, then response) before abort; 0 disables the timeout.

Ports:
- axil_aclk  in  1  single clock.
- axil_rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_W  target address.
- cmd_wdata  in  32  write data; ignored for reads.
- rsp_valid  out  1  result present.
- rsp_ready  in  1  result consumed.
- rsp_rdata  out  32  read data; 0 for writes.
- rsp_resp  out  2  BRESP/RRESP; 2'b10 on timeout.
- rsp_timeout  out  1  transaction aborted by timeout.
- m_axil_awvalid/awaddr[ADDR_W]/awready  out/out/in  AW channel.
- m_axil_wvalid/wdata[32]/wstrb[4]/wready  out/out/out/in  W channel; wstrb is always 4'hF.
- m_axil_bvalid/bresp[2]/bready  in/in/out  B channel.
- m_axil_arvalid/araddr[ADDR_W]/arready  out/out/in  AR channel.
- m_axil_rvalid/rdata[32]/rresp[2]/rready  in/in/in/out  R channel.

Behaviour:
- Reset: state IDLE, timeout counter 0. All outputs 0 except wstrb = 4'hF. The cmd_ready reset value is 0; it rises in the first cycle after reset deasserts.
- States: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, RSP.
- IDLE:
  - cmd_ready = 1.
  - On handshake, latch addr/wdata/write, clear the timeout counter, and go to WR_REQ or RD_REQ.
  - Registered outputs: awvalid/wvalid (or arvalid) assert the cycle after the command handshake.
- WR_REQ:
  - awvalid and wvalid are asserted together; each drops independently after its own handshake.
  - AW and W may complete in the same cycle or in either order.
  - Go to WR_RESP when both are done.
  - bready asserts on WR_RESP entry, never earlier.
- WR_RESP: bready = 1. On bvalid, capture bresp, set rdata = 0, go to RSP.
- RD_REQ: arvalid = 1 until arready, then go to RD_RESP.
- RD_RESP: rready = 1. On rvalid, capture rdata/rresp, go to RSP.
- RSP:
  - rsp_valid = 1; all rsp_* fields are held stable until rsp_ready.
  - Then return to IDLE, with cmd_ready = 1 the next cycle.
  - Throughput: at most one command in flight, no pipelining.
- Timeout (TIMEOUT_CYCLES > 0):
  - 16-bit counter, cleared on every state change, incremented each cycle in WR_REQ/WR_RESP/RD_REQ/RD_RESP.
  - When it reaches TIMEOUT_CYCLES-1 without completing the phase: deassert all AXI valids/readies, go to RSP with rsp_resp = 2'b10, rsp_timeout = 1, rsp_rdata = 0.
  - Late B/R beats arriving after an abort are ignored: bready/rready stay 0 outside the response states.
- A beat arriving in the same cycle as the timeout expiry wins: normal completion, no timeout flag.
- bvalid/rvalid seen outside WR_RESP/RD_RESP are ignored.
- Reset mid-transaction: return to IDLE immediately and drop all valids; no response is emitted.
- Address and data are presented unmodified, with no alignment check.

Optional Feature:
- Macro: AXIL_CFG_INITIATOR_STATS_EN.
- When defined, adds three outputs: stat_wr_cnt[31:0], stat_rd_cnt[31:0], stat_err_cnt[31:0].
- Increment rules:
  - stat_wr_cnt / stat_rd_cnt increment on each RSP→IDLE transition of their type.
  - stat_err_cnt increments when the response is non-OKAY or timed out.
- Counters wrap modulo 2^32 and reset to 0.
- When the macro is not defined, the ports and logic are absent and behaviour is otherwise identical.

Test Plan:
- Write, slave ready: cmd write addr=0x0000_1000, wdata=0x0000_0003; awready and wready high. Expect AW/W in the cycle after cmd accept, bready next cycle. With bresp=0: rsp_resp=0, rsp_rdata=0, rsp_timeout=0.
- Write, skewed channels: wready 3 cycles before awready, then bvalid 5 cycles later with bresp=2'b10. Expect wvalid drops after its handshake, awvalid held until accepted, rsp_resp=2'b10.
- Read with backpressure: cmd read addr=0x0000_1004; slave returns rdata=0xDEAD_BEEF, rresp=0; rsp_ready held low for 4 cycles. Expect rsp fields stable for those 4 cycles, then cmd_ready=1 the cycle after handshake.
- Timeout: TIMEOUT_CYCLES=16, arready held 0. Expect arvalid drops after 16 cycles, rsp_timeout=1, rsp_resp=2'b10, rsp_rdata=0. A late rvalid is then ignored (rready stays 0).
- Reset mid-transaction: axil_rst pulse during WR_RESP. Expect all outputs 0 next cycle, no rsp_valid, and the next write completes normally.
- STATS_EN build: 3 writes (one SLVERR) and 2 reads. Expect stat_wr_cnt=3, stat_rd_cnt=2, stat_err_cnt=1.
